uart_tx_arb: RTL
================

Name: uart_tx_arb

Overview:
Round-robin arbiter that shares the UART transmit FIFO write port (wr_uart/w_data/tx_full) among NREQ byte producers, e.g. CPU mailbox, debug monitor and DMA.
Supports packet locking: a granted requester keeps ownership until it presents a byte flagged last, so multi-byte messages are never interleaved.
A lock timeout releases a stalled owner.
Sits between the producers and the uart block's transmit side.

Parameters:
NREQ, 4, number of requesters (2..8)
LOCK_TO, 1024, cycles an owner may leave req low while locked before forced release; 0 disables the timeout
CW, 11, width of the timeout counter; must hold LOCK_TO

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester byte valid; data/last must be stable while req is high
last  in  NREQ  per-requester end-of-packet flag, qualified by req
data  in  NREQ*8  per-requester byte; requester i uses bits [8i+7:8i]
ack  out  NREQ  one-hot, one-cycle pulse: requester's byte written to FIFO
tx_full  in  1  UART TX FIFO full
wr_uart  out  1  FIFO write strobe, one-cycle pulse
w_data  out  8  FIFO write data, valid when wr_uart=1
busy  out  1  high in ISSUE or LOCK
owner  out  $clog2(NREQ)  current/last granted index
lock_timeout  out  1  one-cycle pulse on forced lock release

Behaviour:
- Reset, asynchronous, on reset_n=0:
  - outputs: ack=0, wr_uart=0, w_data=0, busy=0, owner=0, lock_timeout=0
  - internal: state=IDLE, rr_ptr=NREQ-1, to_cnt=0
  - An in-flight wr_uart/ack is dropped immediately. No partial write is retried.
- All outputs are registered.
- States: IDLE, ISSUE, LOCK.
- IDLE:
  - If tx_full=0 and any req: pick the winner by round-robin. Search order is rr_ptr+1, rr_ptr+2, ... mod NREQ.
  - On the next edge: wr_uart=1, w_data=data[winner], ack[winner]=1, owner=winner, rr_ptr=winner, latch last[winner], go to ISSUE.
  - If tx_full=1: no grant, stay in IDLE.
- ISSUE: lasts exactly one cycle, the cycle where wr_uart/ack are high.
  - Next state: IDLE if the latched last=1, else LOCK with to_cnt=0.
  - The two-cycle minimum spacing between writes guarantees the requester has seen ack and that tx_full reflects the write.
- LOCK: only the owner is eligible.
  - owner req=1 and tx_full=0: issue as in IDLE (winner=owner) and go to ISSUE; to_cnt=0.
  - owner req=1 and tx_full=1: wait; to_cnt is held at 0 (backpressure is not a timeout).
  - owner req=0: to_cnt increments.
  - When LOCK_TO!=0 and to_cnt reaches LOCK_TO-1 with req still low: next edge pulses lock_timeout=1 and goes to IDLE. rr_ptr stays at the owner, so others get priority.
  - Requests from non-owners are ignored; they hold req and are not acked.
- Single-byte packets (last=1 on the first byte) never enter LOCK.
- Maximum throughput is one byte per 2 cycles.
- A requester must deassert req, or present its next byte, in the cycle ack is high. The arbiter never samples req during ISSUE, so a held req is not double-written.
- Simultaneous events:
  - Timeout expiry and owner req rising in the same cycle: req wins; issue the byte, no timeout pulse.
  - tx_full rising in the ISSUE cycle is honoured at the next decision.
- w_data holds its value after wr_uart falls.
- busy=1 in ISSUE and LOCK.

Test Plan:
- Single requester: req[0]=1, data=0x41, last=1, tx_full=0 -> exactly one wr_uart pulse with w_data=0x41, ack=0001 in the same cycle, returns to IDLE, busy=0 two cycles after the request.
- Fairness: req=1111 continuously, all last=1 -> write order 0,1,2,3,0,1; wr_uart high every other cycle.
- Packet lock: req0 sends 3 bytes 0x10,0x11,0x12 (last on the third) while req1 holds 0x55 -> FIFO receives 0x10,0x11,0x12,0x55, never interleaved.
- Backpressure: tx_full=1 for 20 cycles mid-packet with owner req=1 -> no wr_uart, no lock_timeout (LOCK_TO=8); the byte is written 1 cycle after tx_full falls.
- Timeout: LOCK_TO=8, owner sends a non-last byte then drops req while req2=1 -> lock_timeout pulses 8 cycles after entering LOCK; req2's byte is written next.
- Async reset: assert reset_n=0 during the ISSUE cycle -> wr_uart/ack fall without a clock edge; after release, requester 0 has first priority.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing the UART TX FIFO write port among NREQ byte
// producers, with per-packet ownership locking and a stalled-owner timeout.
module uart_tx_arb #(
  parameter int NREQ    = 4,
  parameter int LOCK_TO = 1024,
  parameter int CW      = 11
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         last,
  input  logic [NREQ*8-1:0]       data,
  output logic [NREQ-1:0]         ack,
  input  logic                    tx_full,
  output logic                    wr_uart,
  output logic [7:0]              w_data,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    lock_timeout
);

  localparam int          OW = $clog2(NREQ);
  localparam int unsigned NR = NREQ;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_LOCK  = 2'd2;

  localparam logic [CW-1:0] TO_LAST = (LOCK_TO == 0) ? '0 : CW'(LOCK_TO - 1);

  logic [1:0]    state;
  logic [OW-1:0] rr_ptr;
  logic [OW-1:0] rr_win;
  logic [OW-1:0] cand;
  logic [OW-1:0] sel;
  logic          rr_hit;
  logic          do_issue;
  logic          last_q;
  logic [CW-1:0] to_cnt;
  logic [7:0]    bytes [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_bytes
    assign bytes[g] = data[8*g +: 8];
  end

  // First requester found scanning upward from the slot after the last winner.
  always_comb begin
    rr_win = '0;
    rr_hit = 1'b0;
    cand   = '0;
    for (int unsigned i = 1; i <= NR; i++) begin
      cand = OW'((32'(rr_ptr) + i) % NR);
      if (!rr_hit && req[cand]) begin
        rr_hit = 1'b1;
        rr_win = cand;
      end
    end
  end

  always_comb begin
    sel      = rr_win;
    do_issue = 1'b0;
    case (state)
      S_IDLE: do_issue = rr_hit && !tx_full;
      S_LOCK: begin
        sel      = owner;
        do_issue = req[owner] && !tx_full;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      rr_ptr       <= OW'(NREQ - 1);
      to_cnt       <= '0;
      last_q       <= 1'b0;
      ack          <= '0;
      wr_uart      <= 1'b0;
      w_data       <= '0;
      busy         <= 1'b0;
      owner        <= '0;
      lock_timeout <= 1'b0;
    end else begin
      wr_uart      <= 1'b0;
      ack          <= '0;
      lock_timeout <= 1'b0;
      if (do_issue) begin
        wr_uart <= 1'b1;
        w_data  <= bytes[sel];
        ack     <= NREQ'(1) << sel;
        owner   <= sel;
        rr_ptr  <= sel;
        last_q  <= last[sel];
        to_cnt  <= '0;
        state   <= S_ISSUE;
        busy    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: busy <= 1'b0;
          S_ISSUE: begin
            to_cnt <= '0;
            if (last_q) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_LOCK;
              busy  <= 1'b1;
            end
          end
          S_LOCK: begin
            // Backpressure with the owner still requesting is not a stall.
            if (req[owner]) begin
              to_cnt <= '0;
            end else if (LOCK_TO != 0 && to_cnt == TO_LAST) begin
              lock_timeout <= 1'b1;
              to_cnt       <= '0;
              state        <= S_IDLE;
              busy         <= 1'b0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
